// File: rtl/seq_reset_pipe_bank_pkg.sv
// Shared types and helpers for the sequential-reset pipeline bank.
// The stage struct is fixed to a default width because packages cannot carry parametrised types.
package seq_reset_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef struct packed {
      logic                     v;
      logic [DEFAULT_WIDTH-1:0] d;
   } stage_t;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/seq_reset_pipe_bank_stage.sv
// One elastic valid/data stage with async reset, synchronous flush and a programmable reset value.
module seq_reset_pipe_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             down_rdy,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             rdy
);

   assign rdy = !v || down_rdy;

   // Data only loads alongside a valid bit, so bubbles never capture undriven input data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= 1'b0;
         d <= RESET_VAL;
      end else if (flush) begin
         v <= 1'b0;
         d <= RESET_VAL;
      end else if (rdy) begin
         v <= up_valid;
         if (up_valid) begin
            d <= up_data;
         end
      end
   end

endmodule

// File: rtl/seq_reset_pipe_bank.sv
// Parametrised elastic register pipeline built from chained seq_reset_pipe_stage instances.
// Optional occupancy counter output is enabled by defining SEQ_RESET_PIPE_OCC_EN.
module seq_reset_pipe_bank
   import seq_reset_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   input  logic                        out_ready
`ifdef SEQ_RESET_PIPE_OCC_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH:0]   rdy;

   assign rdy[DEPTH] = out_ready;

   // Stage i is fed by stage i-1 and sees the ready of stage i+1; the last one sees out_ready.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      if (i == 0) begin : g_first
         assign up_valid = in_valid;
         assign up_data  = in_data;
      end else begin : g_next
         assign up_valid = v[i-1];
         assign up_data  = d[i-1];
      end

      seq_reset_pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .up_valid (up_valid),
         .up_data  (up_data),
         .down_rdy (rdy[i+1]),
         .v        (v[i]),
         .d        (d[i]),
         .rdy      (rdy[i])
      );
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

`ifdef SEQ_RESET_PIPE_OCC_EN
   localparam int OW = occ_width(DEPTH);

   logic [OW-1:0] occ_cnt;
   logic          xfer_in;
   logic          xfer_out;

   assign xfer_in  = in_valid && in_ready;
   assign xfer_out = out_valid && out_ready;

   // Registered count of held entries; simultaneous in and out cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_cnt <= '0;
      end else if (flush) begin
         occ_cnt <= '0;
      end else if (xfer_in && !xfer_out) begin
         occ_cnt <= occ_cnt + OW'(1);
      end else if (!xfer_in && xfer_out) begin
         occ_cnt <= occ_cnt - OW'(1);
      end
   end

   assign occupancy = occ_cnt;
`endif

endmodule

// File: tb/tb_seq_reset_pipe_bank.sv
// Self-checking bench for seq_reset_pipe_bank: directed vector table, randomized traffic
// against a position-tracking reference model, and async reset during a stall.
module tb_seq_reset_pipe_bank;

   localparam int         WIDTH = 8;
   localparam int         DEPTH = 2;
   localparam logic [7:0] RV    = 8'hA5;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SEQ_RESET_PIPE_OCC_EN
   logic [1:0] occupancy;
   logic       flush3;
   logic       in_valid3;
   logic [7:0] in_data3;
   logic       in_ready3;
   logic       out_valid3;
   logic [7:0] out_data3;
   logic       out_ready3;
   logic [1:0] occupancy3;
`endif

   seq_reset_pipe_bank #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .RESET_VAL (RV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef SEQ_RESET_PIPE_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

`ifdef SEQ_RESET_PIPE_OCC_EN
   seq_reset_pipe_bank #(
      .WIDTH     (WIDTH),
      .DEPTH     (3),
      .RESET_VAL (RV)
   ) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush3),
      .in_valid  (in_valid3),
      .in_data   (in_data3),
      .in_ready  (in_ready3),
      .out_valid (out_valid3),
      .out_data  (out_data3),
      .out_ready (out_ready3),
      .occupancy (occupancy3)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: in-flight items, oldest first, each with its stage position.
   int         mpos[$];
   logic [7:0] mdat[$];

   function automatic bit model_out_valid();
      return (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
   endfunction

   // An item advances unless it sits in an unbroken run of items reaching a stalled output.
   function automatic bit model_in_ready(input bit orr);
      bit mv;
      mv = 1'b1;
      if (mpos.size() == 0) return 1'b1;
      foreach (mpos[k]) begin
         if (k == 0) mv = (mpos[0] == DEPTH - 1) ? orr : 1'b1;
         else if (mpos[k] + 1 != mpos[k-1]) mv = 1'b1;
      end
      return (mpos[mpos.size()-1] == 0) ? mv : 1'b1;
   endfunction

   task automatic model_edge(input bit fl, input bit iv, input logic [7:0] din, input bit orr);
      int         npos[$];
      logic [7:0] ndat[$];
      bit         mv;
      bit         ir;
      if (fl) begin
         mpos.delete();
         mdat.delete();
         return;
      end
      ir = model_in_ready(orr);
      mv = 1'b1;
      foreach (mpos[k]) begin
         if (k == 0) mv = (mpos[0] == DEPTH - 1) ? orr : 1'b1;
         else if (mpos[k] + 1 != mpos[k-1]) mv = 1'b1;
         if (!mv) begin
            npos.push_back(mpos[k]);
            ndat.push_back(mdat[k]);
         end else if (mpos[k] != DEPTH - 1) begin
            npos.push_back(mpos[k] + 1);
            ndat.push_back(mdat[k]);
         end
      end
      if (iv && ir) begin
         npos.push_back(0);
         ndat.push_back(din);
      end
      mpos = npos;
      mdat = ndat;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model();
      checkOutput("model in_ready", 32'(in_ready), 32'(model_in_ready(out_ready)));
      checkOutput("model out_valid", 32'(out_valid), 32'(model_out_valid()));
      if (model_out_valid()) checkOutput("model out_data", 32'(out_data), 32'(mdat[0]));
`ifdef SEQ_RESET_PIPE_OCC_EN
      checkOutput("model occupancy", 32'(occupancy), 32'(mpos.size()));
`endif
   endtask

   // Drive inputs after a falling edge, check before the next rising edge, then advance the model.
   task automatic applyStimulus(input bit fl, input bit iv, input logic [7:0] din, input bit orr);
      flush     = fl;
      in_valid  = iv;
      in_data   = din;
      out_ready = orr;
      #1;
      check_model();
      @(posedge clk);
      model_edge(fl, iv, din, orr);
      @(negedge clk);
   endtask

   typedef struct {
      bit         fl;
      bit         iv;
      logic [7:0] din;
      bit         orr;
      bit         exp_ir;
      bit         exp_ov;
      logic [7:0] exp_od;
      bit         chk_od;
   } vec_t;

   vec_t vecs[25];

   initial begin
      vecs[0]  = '{0, 1, 8'h01, 1, 1, 0, RV,    1};
      vecs[1]  = '{0, 1, 8'h02, 1, 1, 0, RV,    1};
      vecs[2]  = '{0, 1, 8'h03, 1, 1, 1, 8'h01, 1};
      vecs[3]  = '{0, 0, 8'h00, 1, 1, 1, 8'h02, 1};
      vecs[4]  = '{0, 0, 8'h00, 1, 1, 1, 8'h03, 1};
      vecs[5]  = '{0, 0, 8'h00, 0, 1, 0, 8'h03, 1};
      vecs[6]  = '{0, 1, 8'h10, 0, 1, 0, 8'h03, 1};
      vecs[7]  = '{0, 1, 8'h11, 0, 1, 0, 8'h03, 1};
      vecs[8]  = '{0, 1, 8'h12, 0, 0, 1, 8'h10, 1};
      vecs[9]  = '{0, 1, 8'h12, 0, 0, 1, 8'h10, 1};
      vecs[10] = '{0, 1, 8'h12, 1, 1, 1, 8'h10, 1};
      vecs[11] = '{0, 0, 8'h00, 1, 1, 1, 8'h11, 1};
      vecs[12] = '{0, 0, 8'h00, 1, 1, 1, 8'h12, 1};
      vecs[13] = '{0, 0, 8'h00, 1, 1, 0, 8'h12, 1};
      vecs[14] = '{0, 1, 8'h30, 0, 1, 0, 8'h12, 1};
      vecs[15] = '{0, 1, 8'h31, 0, 1, 0, 8'h12, 1};
      vecs[16] = '{1, 1, 8'h77, 0, 0, 1, 8'h30, 1};
      vecs[17] = '{0, 0, 8'h00, 1, 1, 0, RV,    1};
      vecs[18] = '{0, 0, 8'h00, 1, 1, 0, RV,    1};
      vecs[19] = '{0, 1, 8'h20, 1, 1, 0, RV,    1};
      vecs[20] = '{0, 0, 8'hEE, 1, 1, 0, RV,    1};
      vecs[21] = '{0, 1, 8'h21, 1, 1, 1, 8'h20, 1};
      vecs[22] = '{0, 0, 8'hEE, 1, 1, 0, 8'h00, 0};
      vecs[23] = '{0, 0, 8'h00, 1, 1, 1, 8'h21, 1};
      vecs[24] = '{0, 0, 8'h00, 1, 1, 0, 8'h21, 1};
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
`ifdef SEQ_RESET_PIPE_OCC_EN
      flush3     = 1'b0;
      in_valid3  = 1'b0;
      in_data3   = 8'h00;
      out_ready3 = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_data", 32'(out_data), 32'(RV));
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef SEQ_RESET_PIPE_OCC_EN
      // Occupancy on a DEPTH=3 instance: fill while stalled, swap in and out, then flush.
      checkOutput("occ3 reset", 32'(occupancy3), 32'd0);
      out_ready3 = 1'b0;
      in_valid3  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_data3 = 8'(8'h40 + i);
         @(negedge clk);
         checkOutput("occ3 fill", 32'(occupancy3), 32'(i));
      end
      checkOutput("occ3 full in_ready", 32'(in_ready3), 32'd0);
      out_ready3 = 1'b1;
      in_data3   = 8'h50;
      @(negedge clk);
      checkOutput("occ3 swap", 32'(occupancy3), 32'd3);
      flush3 = 1'b1;
      @(negedge clk);
      checkOutput("occ3 flush", 32'(occupancy3), 32'd0);
      flush3     = 1'b0;
      in_valid3  = 1'b0;
      out_ready3 = 1'b0;
`endif

      for (int i = 0; i < 25; i++) begin
         flush     = vecs[i].fl;
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].din;
         out_ready = vecs[i].orr;
         #1;
         checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
         checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].chk_od)
            checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
         check_model();
         @(posedge clk);
         model_edge(vecs[i].fl, vecs[i].iv, vecs[i].din, vecs[i].orr);
         @(negedge clk);
      end

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(31) == 0), ($urandom_range(2) != 0),
                       8'($urandom), ($urandom_range(2) != 0));
      end

      // Fill under stall, then drop reset mid-cycle and check outputs before any clock edge.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      model_edge(1'b0, 1'b1, in_data, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("async reset out_data", 32'(out_data), 32'(RV));
      checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
      mpos.delete();
      mdat.delete();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_reset_pipe_bank.md
Name: seq_reset_pipe_bank

Overview:
- Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data, each stage with a valid bit and backpressure.
- Async active-low reset and a synchronous flush; every register reloads a parametrised reset value.
- Used as the general sequential-reset pipeline in the netlist frontend benchmarks.
- Exercises async reset, sync clear, enable/hold and handshakes in one block, with multi-bit data and reset-value variants.

Parameters:
- WIDTH, 8: data width in bits, minimum 1.
- DEPTH, 2: number of pipeline stages, minimum 1.
- RESET_VAL, '0: WIDTH-bit value loaded into every data register on reset or flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- flush  input  1  synchronous clear of all stages; active high.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  the block accepts data this cycle.
- out_valid  output  1  the last stage holds valid data.
- out_data  output  WIDTH  data in the last stage.
- out_ready  input  1  downstream accepts data.

Behaviour:
- State per stage i (0..DEPTH-1):
  - v[i]: valid bit.
  - d[i]: WIDTH-bit data register.
  - Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Advance rule:
  - rdy[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = rdy[0]; the ready chain is purely combinational.
- Per cycle, when not flushing:
  - Stage 0 loads in_data and sets v[0] = in_valid when rdy[0] = 1.
  - Stage i>0 loads d[i-1] and sets v[i] = v[i-1] when rdy[i] = 1.
  - A stage with rdy = 0 holds both data and valid.
- Data registers load only when the incoming valid is 1. A bubble clears v but leaves d unchanged, so no capture of X data.
- Latency and throughput:
  - DEPTH cycles from accept to out_valid with no stall.
  - Full throughput: 1 transfer per cycle while out_ready = 1.
- Handshake:
  - Transfer in = in_valid && in_ready.
  - Transfer out = out_valid && out_ready.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- Reset (rst_n = 0), immediately and independent of clk:
  - All v = 0 and all d = RESET_VAL.
  - Outputs: out_valid = 0, out_data = RESET_VAL, in_ready = 1.
- Flush (flush = 1 at a rising edge):
  - All v = 0 and all d = RESET_VAL; any data presented that cycle is dropped.
  - Flush beats in_valid and out_ready in the same cycle.
  - in_ready is not gated by flush.
  - Any transfer out in the flush cycle still counts as delivered.
- Boundaries:
  - Full pipeline with out_ready = 0 gives in_ready = 0.
  - A simultaneous transfer out and transfer in on a full pipeline is allowed; contents shift by one.
  - Reset in the middle of a stall discards all contents.
  - DEPTH = 1 degenerates to a single skid-free register.

Optional Feature:
- Macro: SEQ_RESET_PIPE_OCC_EN.
- Defined:
  - Extra output occupancy [$clog2(DEPTH+1)-1:0], equal to the number of set v bits. It is a registered counter, not a popcount.
  - Counter update each cycle: +1 on transfer in only, -1 on transfer out only, unchanged when both occur.
  - Counter goes to 0 on reset or flush.
  - Counter never exceeds DEPTH.
- Undefined: the occupancy port and its counter do not exist; all other behaviour is identical.

Decomposition:
- Package seq_reset_pkg holds:
  - typedef for the stage state struct {logic v; logic [W-1:0] d} as a parametrised-width helper, or a localparam default width if the tool lacks parametrised types.
  - function occ_width(depth) returning $clog2(depth+1).
- Sub-module seq_reset_pipe_stage: one valid/data stage with its rdy in and out, async reset, flush and RESET_VAL.
- The top generates DEPTH instances of the sub-module and chains them.

Test Plan:
- Reset: WIDTH=8, DEPTH=2, RESET_VAL=8'hA5; drive rst_n low mid-cycle -> out_valid = 0, out_data = 8'hA5 and in_ready = 1 without waiting for a clk edge.
- Streaming: send 8'h01, 8'h02, 8'h03 on consecutive cycles with out_ready = 1 -> each appears on out_data 2 cycles after accept, back-to-back, out_valid = 1 for 3 cycles.
- Backpressure: hold out_ready = 0 and send 8'h10, 8'h11, 8'h12 -> first two accepted, in_ready = 0 on the third; release out_ready -> outputs 10, 11, 12 in order with no loss or duplication.
- Flush priority: with 2 entries held, assert flush together with in_valid = 1 and data 8'h77 -> next cycle out_valid = 0, all d = RESET_VAL, 8'h77 never emerges.
- Bubble: send 8'h20, idle 1 cycle, send 8'h21 -> out_valid pattern 1, 0, 1; the out_data value during the gap is not checked, d is not loaded from the invalid in_data.
- With SEQ_RESET_PIPE_OCC_EN, DEPTH=3: occupancy goes 0, 1, 2, 3 while filling with out_ready = 0, stays 3 on a simultaneous transfer in and out, and goes to 0 on flush.
